// File: rtl/harmonic_interface.sv
// Serial-configured control block for a two-channel harmonic analog front end.
// Holds a 90-bit config word loaded over scl/cs/din, drives channel controls and a quadrature NCO.
module harmonic_interface (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        scl_in,
    input  logic        cs_in,
    input  logic        din,
    input  logic        multA,
    input  logic        multB,
    output logic        nco_i,
    output logic        nco_q,
    output logic        clk_out,
    output logic        reset_out,
    output logic        scl_out,
    output logic        cs_out,
    output logic        dout,
    output logic [6:0]  swAp,
    output logic [6:0]  swAn,
    output logic [6:0]  swBp,
    output logic [6:0]  swBn,
    output logic        cintAp,
    output logic        cintAn,
    output logic        cintBp,
    output logic        cintBn,
    output logic        zeroAp,
    output logic        zeroAn,
    output logic        zeroBp,
    output logic        zeroBn,
    output logic        fastAp,
    output logic        fastAn,
    output logic        fastBp,
    output logic        fastBn,
    output logic [11:0] tuneAp,
    output logic [11:0] tuneAn,
    output logic [11:0] tuneBp,
    output logic [11:0] tuneBn
);

    localparam int unsigned CFG_W   = 90;
    localparam int unsigned PHASE_W = 16;
    localparam int unsigned SW_W    = 7;
    localparam int unsigned TUNE_W  = 12;

    typedef struct packed {
        logic              cint;
        logic              zero;
        logic              fast;
        logic [TUNE_W-1:0] tune;
    } grp_t;

    typedef struct packed {
        logic [PHASE_W-1:0] nco_freq;
        logic [SW_W-1:0]    sw_a;
        grp_t               ap;
        grp_t               an;
        logic [SW_W-1:0]    sw_b;
        grp_t               bp;
        grp_t               bn;
    } cfg_t;

    logic [2:0]         r_scl_sync;
    logic [2:0]         r_cs_sync;
    logic [1:0]         r_din_sync;
    logic [CFG_W-1:0]   r_sr;
    cfg_t               r_cfg;
    logic               r_dout;
    logic [PHASE_W-1:0] r_phase;

    logic               w_scl_rise;
    logic               w_cs_rise;
    logic               w_shift;
    logic [PHASE_W-1:0] w_phase_q;

    // Bit 2 of each chain is the delayed copy used for edge detect and pass-through
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_scl_sync <= 3'b000;
            r_cs_sync  <= 3'b111;
            r_din_sync <= 2'b00;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], scl_in};
            r_cs_sync  <= {r_cs_sync[1:0], cs_in};
            r_din_sync <= {r_din_sync[0], din};
        end
    end

    assign w_scl_rise = r_scl_sync[1] & ~r_scl_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_shift    = w_scl_rise & ~r_cs_sync[1];

    // Shift register, config latch and daisy-chain output
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_sr   <= '0;
            r_cfg  <= '0;
            r_dout <= 1'b0;
        end else begin
            if (w_shift) begin
                r_sr <= {r_sr[CFG_W-2:0], r_din_sync[1]};
            end
            if (w_cs_rise) begin
                r_cfg <= r_sr;
            end
            r_dout <= r_sr[CFG_W-1];
        end
    end

    // Phase accumulator; a zero frequency word freezes both NCO outputs
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + r_cfg.nco_freq;
        end
    end

    assign w_phase_q = r_phase + PHASE_W'(16'h4000);
    assign nco_i     = r_phase[PHASE_W-1];
    assign nco_q     = w_phase_q[PHASE_W-1];

    assign clk_out   = clk_in;
    assign reset_out = reset_in;
    assign scl_out   = r_scl_sync[2];
    assign cs_out    = r_cs_sync[2];
    assign dout      = r_dout;

    // Polarity select steers each switch word to one half of its channel
    assign swAp = multA ? r_cfg.sw_a : '0;
    assign swAn = multA ? '0 : r_cfg.sw_a;
    assign swBp = multB ? r_cfg.sw_b : '0;
    assign swBn = multB ? '0 : r_cfg.sw_b;

    assign cintAp = r_cfg.ap.cint;
    assign zeroAp = r_cfg.ap.zero;
    assign fastAp = r_cfg.ap.fast;
    assign tuneAp = r_cfg.ap.tune;
    assign cintAn = r_cfg.an.cint;
    assign zeroAn = r_cfg.an.zero;
    assign fastAn = r_cfg.an.fast;
    assign tuneAn = r_cfg.an.tune;
    assign cintBp = r_cfg.bp.cint;
    assign zeroBp = r_cfg.bp.zero;
    assign fastBp = r_cfg.bp.fast;
    assign tuneBp = r_cfg.bp.tune;
    assign cintBn = r_cfg.bn.cint;
    assign zeroBn = r_cfg.bn.zero;
    assign fastBn = r_cfg.bn.fast;
    assign tuneBn = r_cfg.bn.tune;

endmodule

// File: tb/tb_harmonic_interface.sv
// Directed bench for harmonic_interface: serial frames, field mapping, polarity, NCO, daisy chain.
module tb_harmonic_interface;

    logic clk_in, reset_in, scl_in, cs_in, din, multA, multB;
    logic nco_i, nco_q, clk_out, reset_out, scl_out, cs_out, dout;
    logic [6:0]  swAp, swAn, swBp, swBn;
    logic        cintAp, cintAn, cintBp, cintBn;
    logic        zeroAp, zeroAn, zeroBp, zeroBn;
    logic        fastAp, fastAn, fastBp, fastBn;
    logic [11:0] tuneAp, tuneAn, tuneBp, tuneBn;

    harmonic_interface dut (
        .clk_in(clk_in), .reset_in(reset_in), .scl_in(scl_in), .cs_in(cs_in), .din(din),
        .multA(multA), .multB(multB), .nco_i(nco_i), .nco_q(nco_q),
        .clk_out(clk_out), .reset_out(reset_out), .scl_out(scl_out), .cs_out(cs_out), .dout(dout),
        .swAp(swAp), .swAn(swAn), .swBp(swBp), .swBn(swBn),
        .cintAp(cintAp), .cintAn(cintAn), .cintBp(cintBp), .cintBn(cintBn),
        .zeroAp(zeroAp), .zeroAn(zeroAn), .zeroBp(zeroBp), .zeroBn(zeroBn),
        .fastAp(fastAp), .fastAn(fastAn), .fastBp(fastBp), .fastBn(fastBn),
        .tuneAp(tuneAp), .tuneAn(tuneAn), .tuneBp(tuneBp), .tuneBn(tuneBn)
    );

    int checks   = 0;
    int failures = 0;

    logic [89:0] m_sr;
    logic [89:0] m_cfg;
    logic [15:0] m_freq;
    logic [15:0] m_phase;
    logic        exp_q[$];

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference phase accumulator; m_freq is updated by the bench when a latch is due
    always @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) m_phase <= 16'h0;
        else           m_phase <= m_phase + m_freq;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg(input logic [89:0] c);
        logic [15:0] ph_q;
        ph_q = m_phase + 16'h4000;
        chk("swAp", 32'(swAp), multA ? 32'(c[73:67]) : 32'd0);
        chk("swAn", 32'(swAn), multA ? 32'd0 : 32'(c[73:67]));
        chk("swBp", 32'(swBp), multB ? 32'(c[36:30]) : 32'd0);
        chk("swBn", 32'(swBn), multB ? 32'd0 : 32'(c[36:30]));
        chk("cintAp", 32'(cintAp), 32'(c[66]));
        chk("zeroAp", 32'(zeroAp), 32'(c[65]));
        chk("fastAp", 32'(fastAp), 32'(c[64]));
        chk("tuneAp", 32'(tuneAp), 32'(c[63:52]));
        chk("cintAn", 32'(cintAn), 32'(c[51]));
        chk("zeroAn", 32'(zeroAn), 32'(c[50]));
        chk("fastAn", 32'(fastAn), 32'(c[49]));
        chk("tuneAn", 32'(tuneAn), 32'(c[48:37]));
        chk("cintBp", 32'(cintBp), 32'(c[29]));
        chk("zeroBp", 32'(zeroBp), 32'(c[28]));
        chk("fastBp", 32'(fastBp), 32'(c[27]));
        chk("tuneBp", 32'(tuneBp), 32'(c[26:15]));
        chk("cintBn", 32'(cintBn), 32'(c[14]));
        chk("zeroBn", 32'(zeroBn), 32'(c[13]));
        chk("fastBn", 32'(fastBn), 32'(c[12]));
        chk("tuneBn", 32'(tuneBn), 32'(c[11:0]));
        chk("nco_i", 32'(nco_i), 32'(m_phase[15]));
        chk("nco_q", 32'(nco_q), 32'(ph_q[15]));
    endtask

    task automatic check_reset();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_scl_out", 32'(scl_out), 32'd0);
        chk("rst_cs_out", 32'(cs_out), 32'd1);
        chk("rst_reset_out", 32'(reset_out), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'(clk_in));
        check_cfg(90'h0);
    endtask

    // One serial bit; entered and left on a falling clk edge
    task automatic send_bit(input logic b);
        din    = b;
        scl_in = 1'b0;
        repeat (4) @(negedge clk_in);
        scl_in = 1'b1;
        m_sr = {m_sr[88:0], b};
        exp_q.push_back(m_sr[89]);
        repeat (2) @(negedge clk_in);
        chk("scl_out_lag2", 32'(scl_out), 32'd0);
        @(negedge clk_in);
        chk("scl_out_lag3", 32'(scl_out), 32'd1);
        @(negedge clk_in);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL dout_queue observed=empty expected=entry");
        end else begin
            chk("dout", 32'(dout), 32'(exp_q.pop_front()));
        end
        @(negedge clk_in);
        scl_in = 1'b0;
    endtask

    task automatic select_low();
        cs_in = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    // Raise cs and check the three-cycle latch latency
    task automatic latch();
        cs_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("cs_out_lag2", 32'(cs_out), 32'd0);
        chk("pre_latch_tuneAp", 32'(tuneAp), 32'(m_cfg[63:52]));
        @(negedge clk_in);
        chk("cs_out_lag3", 32'(cs_out), 32'd1);
        m_cfg  = m_sr;
        m_freq = m_cfg[89:74];
        check_cfg(m_cfg);
    endtask

    initial begin
        logic [89:0]  frame;
        logic [179:0] dbits;
        logic [9:0]   sbits;

        reset_in = 1'b0;
        scl_in = 1'b0; cs_in = 1'b1; din = 1'b0;
        multA = 1'b0; multB = 1'b0;
        m_sr = '0; m_cfg = '0; m_freq = '0;

        repeat (3) @(negedge clk_in);
        check_reset();
        @(posedge clk_in); #1;
        chk("rst_clk_out_hi", 32'(clk_out), 32'd1);
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Frame load and field mapping
        frame = {16'h4000, 7'h55, 1'b1, 1'b0, 1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 12'h123,
                 7'h2A, 15'h7FFF, 15'h0000};
        select_low();
        for (int i = 89; i >= 0; i--) send_bit(frame[i]);
        latch();
        chk("frame_tuneAp", 32'(tuneAp), 32'hABC);
        chk("frame_cintAp", 32'(cintAp), 32'd1);
        chk("frame_fastAp", 32'(fastAp), 32'd1);
        chk("frame_zeroAn", 32'(zeroAn), 32'd1);
        chk("frame_tuneBp", 32'(tuneBp), 32'hFFF);
        chk("frame_cintBp", 32'(cintBp), 32'd1);

        // NCO at a quarter of the clock: i = 0,0,1,1  q = 0,1,1,0
        for (int k = 0; k < 8; k++) begin
            chk("nco_i_seq", 32'(nco_i), 32'((k % 4) >= 2));
            chk("nco_q_seq", 32'(nco_q), 32'(((k % 4) == 1) || ((k % 4) == 2)));
            @(negedge clk_in);
        end

        // Polarity select is combinational
        multA = 1'b1; #1;
        chk("multA1_swAp", 32'(swAp), 32'h55);
        chk("multA1_swAn", 32'(swAn), 32'h0);
        multA = 1'b0; #1;
        chk("multA0_swAp", 32'(swAp), 32'h0);
        chk("multA0_swAn", 32'(swAn), 32'h55);
        multB = 1'b1; #1;
        chk("multB1_swBp", 32'(swBp), 32'h2A);
        chk("multB1_swBn", 32'(swBn), 32'h0);
        multB = 1'b0; #1;
        chk("multB0_swBp", 32'(swBp), 32'h0);
        chk("multB0_swBn", 32'(swBn), 32'h2A);
        multA = 1'b1; #1;
        check_cfg(m_cfg);
        @(negedge clk_in);

        // Daisy chain: 180 bits, second half carries a zero NCO frequency
        for (int i = 0; i < 180; i++) dbits[i] = 1'($urandom_range(1, 0));
        for (int i = 90; i < 106; i++) dbits[i] = 1'b0;
        select_low();
        for (int i = 0; i < 180; i++) send_bit(dbits[i]);
        latch();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            check_cfg(m_cfg);
        end

        // Short frame: ten new bits land in the low end
        sbits = 10'h2A5;
        select_low();
        for (int i = 9; i >= 0; i--) send_bit(sbits[i]);
        latch();
        chk("short_low_bits", 32'(tuneBn[9:0]), 32'h2A5);

        // Reset mid-frame discards partial data
        select_low();
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        reset_in = 1'b0;
        m_sr = '0; m_cfg = '0; m_freq = '0;
        exp_q.delete();
        #1;
        check_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (4) @(negedge clk_in);
        latch();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
